// File: rtl/riscv_bram_lsu_if.sv
// CPU data-port request/response and byte-wide BRAM port bundle for riscv_bram_lsu.
// slave = the load/store sequencer side, master = CPU plus BRAM side.
interface riscv_bram_lsu_if #(
  parameter int ADDR_LENGTH = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [2:0]             req_funct3;
  logic [ADDR_LENGTH-1:0] req_addr;
  logic [31:0]            req_wdata;
  logic                   resp_valid;
  logic                   resp_err;
  logic [31:0]            resp_rdata;
  logic                   mem_write_en;
  logic [ADDR_LENGTH-1:0] mem_waddr;
  logic [7:0]             mem_wdata;
  logic [ADDR_LENGTH-1:0] mem_raddr;
  logic [7:0]             mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_write_en, mem_waddr, mem_wdata, mem_raddr
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_write_en, mem_waddr, mem_wdata, mem_raddr
  );
endinterface

// File: rtl/riscv_bram_lsu.sv
// Splits one RV32I load/store into 1/2/4 little-endian byte accesses; response n+1 cycles
// after accept (1 on error); req_ready only in IDLE, so a busy block ignores req_valid.
module riscv_bram_lsu #(
  parameter int ADDR_LENGTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  riscv_bram_lsu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_we;
  logic [2:0]             r_funct3;
  logic [ADDR_LENGTH-1:0] r_addr;
  logic [ADDR_LENGTH-1:0] r_raddr;
  logic [31:0]            r_wdata;
  logic [31:0]            r_data;
  logic [1:0]             r_idx;
  logic                   r_err;

  logic                   w_accept;
  logic                   w_illegal;
  logic                   w_misaligned;
  logic                   w_last;
  logic [ADDR_LENGTH-1:0] w_cur_addr;
  logic [31:0]            w_load;

  assign w_accept = bus.req_valid && (r_state == IDLE);

  // funct3 4/5 are load-only; 6/7 and any width code 3 are never legal
  assign w_illegal = (bus.req_funct3[1:0] == 2'd3) ||
                     (bus.req_funct3[2] && (bus.req_we || bus.req_funct3[1]));
  assign w_misaligned = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'd0));

  assign w_last     = (r_idx == (r_funct3[1] ? 2'd3 : {1'b0, r_funct3[0]}));
  assign w_cur_addr = r_addr + ADDR_LENGTH'(r_idx);

  always_comb begin
    w_load = r_data;
    case (r_funct3)
      3'd0:    w_load = {{24{r_data[7]}}, r_data[7:0]};
      3'd1:    w_load = {{16{r_data[15]}}, r_data[15:0]};
      3'd4:    w_load = {24'h0, r_data[7:0]};
      3'd5:    w_load = {16'h0, r_data[15:0]};
      default: w_load = r_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    bus.req_ready    = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.resp_err     = 1'b0;
    bus.resp_rdata   = 32'h0;
    bus.mem_write_en = 1'b0;
    bus.mem_waddr    = w_cur_addr;
    bus.mem_wdata    = r_wdata[{r_idx, 3'b000} +: 8];
    bus.mem_raddr    = r_raddr;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (w_accept) begin
          w_next = (w_illegal || w_misaligned) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_write_en = r_we;
        if (!r_we) begin
          bus.mem_raddr = w_cur_addr;
        end
        if (w_last) begin
          w_next = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = r_err;
        bus.resp_rdata = (r_err || r_we) ? 32'h0 : w_load;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_raddr  <= '0;
      r_wdata  <= 32'h0;
      r_data   <= 32'h0;
      r_idx    <= 2'd0;
      r_err    <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_we     <= bus.req_we;
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        r_data   <= 32'h0;
        r_idx    <= 2'd0;
        r_err    <= w_illegal || w_misaligned;
      end
    end else if (r_state == ACCESS) begin
      if (!r_we) begin
        r_data[{r_idx, 3'b000} +: 8] <= bus.mem_rdata;
        r_raddr                      <= w_cur_addr;
      end
      r_idx <= w_last ? 2'd0 : r_idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_riscv_bram_lsu.sv
// Randomised scoreboard bench for riscv_bram_lsu: a driver pushes expected BRAM accesses and
// responses from a byte-array reference model; a negedge monitor pops and compares them.
module tb_riscv_bram_lsu;

  typedef struct { logic err; logic [31:0] rdata; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;
  typedef struct { logic [31:0] addr; int cyc; } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   started = 1'b0;
  bit   bram_init = 1'b0;

  logic [7:0] bram    [256];
  logic [7:0] ref_mem [256];

  resp_t resp_q[$];
  wr_t   wr_q[$];
  rd_t   rd_q[$];

  riscv_bram_lsu_if #(.ADDR_LENGTH(32)) bus ();

  riscv_bram_lsu #(.ADDR_LENGTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  assign bus.mem_rdata = bram[bus.mem_raddr[7:0]];

  always @(posedge clk) begin
    if (!bram_init) begin
      for (int i = 0; i < 256; i++) bram[i] <= pat(i);
      bram_init <= 1'b1;
    end else if (bus.mem_write_en) begin
      bram[bus.mem_waddr[7:0]] <= bus.mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT write, read step and response must match the head of its queue
  always @(negedge clk) begin
    if (started && rst_n) begin
      if (bus.mem_write_en) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", bus.mem_waddr, 32'hFFFF_FFFF);
        end else begin
          check("wr_cycle", cyc, wr_q[0].cyc);
          check("wr_addr", bus.mem_waddr, wr_q[0].addr);
          check("wr_data", 32'(bus.mem_wdata), 32'(wr_q[0].data));
          void'(wr_q.pop_front());
        end
      end
      if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
        check("rd_cycle", cyc, rd_q[0].cyc);
        check("rd_addr", bus.mem_raddr, rd_q[0].addr);
        check("rd_no_write", 32'(bus.mem_write_en), 32'h0);
        void'(rd_q.pop_front());
      end
      if (bus.resp_valid) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", 32'(bus.resp_valid), 32'h0);
        end else begin
          check("resp_cycle", cyc, resp_q[0].cyc);
          check("resp_err", 32'(bus.resp_err), 32'(resp_q[0].err));
          check("resp_rdata", bus.resp_rdata, resp_q[0].rdata);
          void'(resp_q.pop_front());
        end
      end else begin
        check("idle_rdata", bus.resp_rdata, 32'h0);
        check("idle_err", 32'(bus.resp_err), 32'h0);
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output int acc);
    int waited = 0;
    acc = -1;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    while (!bus.req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (bus.req_ready) begin
      acc = cyc;
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: req_ready low for %0d cycles, expected 1", waited);
    end
  endtask

  // Reference model: legality, byte count and extension taken straight from the ISA rules
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int acc);
    bit          legal;
    int          n;
    logic [31:0] v;
    logic [31:0] ad;
    logic [31:0] e;
    legal = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    n     = 1 << f3[1:0];
    if (!legal || (a % n) != 0) begin
      resp_q.push_back('{err: 1'b1, rdata: 32'h0, cyc: acc + 1});
      return;
    end
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      ad = a + 32'(i);
      if (we) begin
        wr_q.push_back('{addr: ad, data: wd[8*i +: 8], cyc: acc + 1 + i});
        ref_mem[ad[7:0]] = wd[8*i +: 8];
      end else begin
        rd_q.push_back('{addr: ad, cyc: acc + 1 + i});
        v[8*i +: 8] = ref_mem[ad[7:0]];
      end
    end
    case (f3)
      3'd0:    e = 32'($signed(v[7:0]));
      3'd1:    e = 32'($signed(v[15:0]));
      3'd4:    e = 32'(v[7:0]);
      3'd5:    e = 32'(v[15:0]);
      default: e = v;
    endcase
    resp_q.push_back('{err: 1'b0, rdata: we ? 32'h0 : e, cyc: acc + n + 1});
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int acc);
    send(we, f3, a, wd, acc);
    if (acc >= 0) model(we, f3, a, wd, acc);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'h1);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
    check({tag, "_resp_err"}, 32'(bus.resp_err), 32'h0);
    check({tag, "_resp_rdata"}, bus.resp_rdata, 32'h0);
    check({tag, "_write_en"}, 32'(bus.mem_write_en), 32'h0);
    check({tag, "_waddr"}, bus.mem_waddr, 32'h0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'h0);
    check({tag, "_raddr"}, bus.mem_raddr, 32'h0);
  endtask

  initial begin
    int          acc;
    int          acc2;
    int          bad_bytes;
    int          waited;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    started = 1'b1;

    issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, acc);
    idle(1);
    issue(1'b0, 3'd2, 32'h10, 32'h0, acc);
    issue(1'b0, 3'd0, 32'h13, 32'h0, acc);
    issue(1'b0, 3'd4, 32'h13, 32'h0, acc);
    issue(1'b0, 3'd1, 32'h12, 32'h0, acc);
    issue(1'b0, 3'd5, 32'h12, 32'h0, acc);
    idle(2);
    issue(1'b0, 3'd2, 32'h11, 32'h0, acc);
    issue(1'b1, 3'd1, 32'h13, 32'h1234_5678, acc);
    issue(1'b0, 3'd3, 32'h10, 32'h0, acc);
    issue(1'b1, 3'd6, 32'h10, 32'h0, acc);
    idle(1);

    // second request held on req_valid must wait for IDLE after the response
    issue(1'b1, 3'd0, 32'h20, 32'h1234_5678, acc);
    issue(1'b0, 3'd0, 32'h20, 32'h0, acc2);
    check("b2b_accept_cycle", acc2, acc + 3);
    idle(3);

    send(1'b1, 3'd2, 32'h30, 32'hAABB_CCDD, acc);
    if (acc >= 0) begin
      wr_q.push_back('{addr: 32'h30, data: 8'hDD, cyc: acc + 1});
      wr_q.push_back('{addr: 32'h31, data: 8'hCC, cyc: acc + 2});
      ref_mem[8'h30] = 8'hDD;
      ref_mem[8'h31] = 8'hCC;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("midop_reset");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1 check("ready_after_release", 32'(bus.req_ready), 32'h1);
      idle(2);
      check("rst_byte30", 32'(bram[8'h30]), 32'h0000_00DD);
      check("rst_byte31", 32'(bram[8'h31]), 32'h0000_00CC);
      check("rst_byte32", 32'(bram[8'h32]), 32'(pat(32'h32)));
      check("rst_byte33", 32'(bram[8'h33]), 32'(pat(32'h33)));
    end

    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      if (!we && $urandom_range(0, 3) == 0) f3 = 3'($urandom_range(4, 5));
      a = $urandom;
      if ($urandom_range(0, 9) < 7) a[1:0] = 2'b00;
      issue(we, f3, a, $urandom, acc);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(1);
    waited = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("resp_queue_drained", resp_q.size(), 32'h0);
    check("write_queue_drained", wr_q.size(), 32'h0);
    check("read_queue_drained", rd_q.size(), 32'h0);

    bad_bytes = 0;
    for (int i = 0; i < 256; i++) if (bram[i] !== ref_mem[i]) bad_bytes++;
    check("bram_contents_bad_bytes", bad_bytes, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
